gpr_multi: RTL

Parametrised general-purpose register file for the 5-stage MIPS core. It generalises the single-write, two-read `gpr` to a configurable data width and depth, NUM_RD read ports and two write ports (WB plus a second retire/load-return port). It supports a hard-wired zero register, a defined same-address write priority and optional same-cycle write-to-read bypass. It sits between decode (read ports) and writeback (write ports).

---
 rtl/gpr_multi.sv | 67 ++++++
 1 files changed

// File: rtl/gpr_multi.sv
// Multi-port general-purpose register file: NUM_RD combinational read ports, two write ports
// (port 1 wins on same-address collision), optional hard-wired zero register; GPR_BYPASS_EN enables write-to-read bypass.
module gpr_multi #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic wr0_ok;
    logic wr1_ok;

    // Writes to register 0 are squashed here so neither storage nor bypass can see them.
    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    always_comb begin
        mem_d = mem_q;
        // NOTE: blocking assignments in order make the later port-1 write override port 0 on a shared address.
        if (wr0_ok) mem_d[waddr0] = wdata0;
        if (wr1_ok) mem_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every entry is reset here because the pipeline relies on a known-zero register file.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = mem_q[ra];
`ifdef GPR_BYPASS_EN
            if (wr0_ok && (waddr0 == ra)) rd_val = wdata0;
            if (wr1_ok && (waddr1 == ra)) rd_val = wdata1;
`endif
            if ((ZERO_REG != 0) && (ra == '0)) rd_val = '0;
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_val;
    end

endmodule
